systolic_feed_scheduler: RTL

Controller that sequences one matrix multiply on the systolic array. It captures operand matrix A (row-major) and operand matrix B (column-major, as delivered by the column extractor) on a start request. It then drives the array's west and north edges with diagonally skewed operand streams, clears and steps the array, waits for pipeline drain, and reports completion. It sits between the host/operand buffers and the PE grid.

---
 rtl/systolic_feed_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/systolic_feed_scheduler.sv
// systolic_feed_scheduler: sequences one skewed-operand matrix multiply on the systolic array
// Ports: clk/rst_n (async active-low), start (sampled in IDLE), hold (freezes FEED/DRAIN),
//        a_flat/b_cols_flat operand inputs captured on start, a_edge/b_edge + a_vld/b_vld
//        west/north edge streams, clear_acc, array_en, busy, done. All outputs registered.
module systolic_feed_scheduler #(
    parameter int M          = 6,
    parameter int K          = 6,
    parameter int N          = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PE_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         hold,
    input  logic [M*K*DATA_WIDTH-1:0]    a_flat,
    input  logic [N*K*DATA_WIDTH-1:0]    b_cols_flat,
    output logic [M*DATA_WIDTH-1:0]      a_edge,
    output logic [N*DATA_WIDTH-1:0]      b_edge,
    output logic [M-1:0]                 a_vld,
    output logic [N-1:0]                 b_vld,
    output logic                         clear_acc,
    output logic                         array_en,
    output logic                         busy,
    output logic                         done
);
    localparam int DW   = DATA_WIDTH;
    localparam int F    = K + M + N - 2;
    localparam int CMAX = F > PE_LAT ? F : PE_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [M*K*DW-1:0]       a_st;
    logic [N*K*DW-1:0]       b_st;
    logic [M*DW-1:0]         a_nxt;
    logic [N*DW-1:0]         b_nxt;
    logic [M-1:0]            av_nxt;
    logic [N-1:0]            bv_nxt;
    int                      ft;
    // Edge values are computed for the feed step about to be presented, so they can be registered.
    always_comb begin
        ft     = (state == CLEAR) ? 0 : int'(cnt) + 1;
        a_nxt  = '0;
        b_nxt  = '0;
        av_nxt = '0;
        bv_nxt = '0;
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++)
                if (ft == i + k) begin
                    av_nxt[i]            = 1'b1;
                    a_nxt[i*DW +: DW]    = a_st[(i*K+k)*DW +: DW];
                end
        for (int j = 0; j < N; j++)
            for (int k = 0; k < K; k++)
                if (ft == j + k) begin
                    bv_nxt[j]            = 1'b1;
                    b_nxt[j*DW +: DW]    = b_st[(j*K+k)*DW +: DW];
                end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_st      <= '0;
            b_st      <= '0;
            a_edge    <= '0;
            b_edge    <= '0;
            a_vld     <= '0;
            b_vld     <= '0;
            clear_acc <= 1'b0;
            array_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            clear_acc <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    a_st      <= a_flat;
                    b_st      <= b_cols_flat;
                    cnt       <= '0;
                    state     <= CLEAR;
                    clear_acc <= 1'b1;
                    busy      <= 1'b1;
                end
                CLEAR: begin
                    state    <= FEED;
                    cnt      <= '0;
                    a_edge   <= a_nxt;
                    b_edge   <= b_nxt;
                    a_vld    <= av_nxt;
                    b_vld    <= bv_nxt;
                    array_en <= 1'b1;
                end
                // A held cycle repeats the current step with array_en low, so each step is consumed once.
                FEED: if (hold) array_en <= 1'b0;
                else if (cnt == CW'(F - 1)) begin
                    state    <= DRAIN;
                    cnt      <= '0;
                    a_edge   <= '0;
                    b_edge   <= '0;
                    a_vld    <= '0;
                    b_vld    <= '0;
                    array_en <= 1'b1;
                end else begin
                    cnt      <= cnt + 1'b1;
                    a_edge   <= a_nxt;
                    b_edge   <= b_nxt;
                    a_vld    <= av_nxt;
                    b_vld    <= bv_nxt;
                    array_en <= 1'b1;
                end
                DRAIN: if (hold) array_en <= 1'b0;
                else if (cnt == CW'(PE_LAT - 1)) begin
                    state    <= DONE;
                    cnt      <= '0;
                    array_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    cnt      <= cnt + 1'b1;
                    array_en <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
